// File: rtl/add_share_sched_pkg.sv
// Shared definitions for the time-shared 32-bit adder scheduler.
// Holds the adder word width, FSM state encodings, the default round-robin
// start value and a small operand-conditioning helper.
package add_share_sched_pkg;

  // Adder word width; the scheduler only supports 32.
  localparam int unsigned DW = 32;

  // Requester that wins the first tie after reset unless overridden.
  localparam bit RR_FIRST_DEFAULT = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2
  } state_e;

  // Subtraction is a + ~b + cin, so b is inverted once at latch time and
  // the adder never needs to know about the operation type.
  function automatic logic [2*DW-1:0] cond_inv(input logic [2*DW-1:0] b,
                                               input logic            sub);
    return sub ? ~b : b;
  endfunction

endpackage

// File: rtl/add32.sv
// Purely combinational 32-bit adder with carry in and carry out.
// Ports: a_i, b_i (32-bit operands), cin_i (carry in),
//        sum_o (32-bit sum), cout_o (carry out of bit 31).
module add32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] sum_o,
  output logic        cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {32'h0, cin_i};

endmodule

// File: rtl/add_share_sched.sv
// Time-shares one add32 between two requesters with round-robin grant;
// 64-bit ops run as two chained beats (LO then HI) carrying c_lo upward.
// Ports: clk/rst_n; per requester N: reqN_valid/ready handshake, reqN_wide,
//        reqN_sub, reqN_cin, reqN_a, reqN_b; rspN_valid one-cycle result
//        pulse; shared rsp_sum/rsp_cout held until the next response; busy
//        is high while an op occupies the adder (LO or HI).
module add_share_sched
  import add_share_sched_pkg::*;
#(
  parameter int unsigned DW       = add_share_sched_pkg::DW,
  parameter bit          RR_FIRST = RR_FIRST_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic            req0_wide,
  input  logic            req0_sub,
  input  logic            req0_cin,
  input  logic [2*DW-1:0] req0_a,
  input  logic [2*DW-1:0] req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic            req1_wide,
  input  logic            req1_sub,
  input  logic            req1_cin,
  input  logic [2*DW-1:0] req1_a,
  input  logic [2*DW-1:0] req1_b,
  output logic            rsp0_valid,
  output logic            rsp1_valid,
  output logic [2*DW-1:0] rsp_sum,
  output logic            rsp_cout,
  output logic            busy
);

  state_e          state_q, state_d;
  logic            rr_last_q, rr_last_d;
  logic            gnt_id_q, gnt_id_d;
  logic [2*DW-1:0] a_q, a_d;
  logic [2*DW-1:0] b_q, b_d;
  logic            cin_q, cin_d;
  logic            wide_q, wide_d;
  logic [DW-1:0]   sum_lo_q, sum_lo_d;
  logic            c_lo_q, c_lo_d;
  logic            rsp0_valid_q, rsp0_valid_d;
  logic            rsp1_valid_q, rsp1_valid_d;
  logic [2*DW-1:0] rsp_sum_q, rsp_sum_d;
  logic            rsp_cout_q, rsp_cout_d;

  logic            gnt_any;
  logic            gnt_id;
  logic [DW-1:0]   add_a, add_b, add_sum;
  logic            add_cin, add_cout;

  // Grant: a lone requester always wins; on a tie the one not served last.
  always_comb begin
    gnt_any = req0_valid | req1_valid;
    if (req0_valid && req1_valid) gnt_id = ~rr_last_q;
    else                          gnt_id = req1_valid;
  end

  assign req0_ready = (state_q == IDLE) & gnt_any & ~gnt_id;
  assign req1_ready = (state_q == IDLE) & gnt_any &  gnt_id;

  // Adder sees only latched operands; HI selects the upper words and the
  // low-beat carry.
  always_comb begin
    add_a   = a_q[DW-1:0];
    add_b   = b_q[DW-1:0];
    add_cin = cin_q;
    if (state_q == HI) begin
      add_a   = a_q[2*DW-1:DW];
      add_b   = b_q[2*DW-1:DW];
      add_cin = c_lo_q;
    end
  end

  add32 u_add32 (
    .a_i    (add_a),
    .b_i    (add_b),
    .cin_i  (add_cin),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  always_comb begin
    state_d      = state_q;
    rr_last_d    = rr_last_q;
    gnt_id_d     = gnt_id_q;
    a_d          = a_q;
    b_d          = b_q;
    cin_d        = cin_q;
    wide_d       = wide_q;
    sum_lo_d     = sum_lo_q;
    c_lo_d       = c_lo_q;
    rsp0_valid_d = 1'b0;
    rsp1_valid_d = 1'b0;
    rsp_sum_d    = rsp_sum_q;
    rsp_cout_d   = rsp_cout_q;

    unique case (state_q)
      IDLE: begin
        if (gnt_any) begin
          a_d       = gnt_id ? req1_a : req0_a;
          b_d       = gnt_id ? cond_inv(req1_b, req1_sub) : cond_inv(req0_b, req0_sub);
          cin_d     = gnt_id ? req1_cin  : req0_cin;
          wide_d    = gnt_id ? req1_wide : req0_wide;
          gnt_id_d  = gnt_id;
          rr_last_d = gnt_id;
          state_d   = LO;
        end
      end
      LO: begin
        sum_lo_d = add_sum;
        c_lo_d   = add_cout;
        if (wide_q) begin
          state_d = HI;
        end else begin
          rsp_sum_d    = {{DW{1'b0}}, add_sum};
          rsp_cout_d   = add_cout;
          rsp0_valid_d = ~gnt_id_q;
          rsp1_valid_d =  gnt_id_q;
          state_d      = IDLE;
        end
      end
      HI: begin
        rsp_sum_d    = {add_sum, sum_lo_q};
        rsp_cout_d   = add_cout;
        rsp0_valid_d = ~gnt_id_q;
        rsp1_valid_d =  gnt_id_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rr_last_q    <= ~RR_FIRST;
      gnt_id_q     <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      cin_q        <= 1'b0;
      wide_q       <= 1'b0;
      sum_lo_q     <= '0;
      c_lo_q       <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp_sum_q    <= '0;
      rsp_cout_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_last_q    <= rr_last_d;
      gnt_id_q     <= gnt_id_d;
      a_q          <= a_d;
      b_q          <= b_d;
      cin_q        <= cin_d;
      wide_q       <= wide_d;
      sum_lo_q     <= sum_lo_d;
      c_lo_q       <= c_lo_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp_sum_q    <= rsp_sum_d;
      rsp_cout_q   <= rsp_cout_d;
    end
  end

  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp_sum    = rsp_sum_q;
  assign rsp_cout   = rsp_cout_q;
  assign busy       = (state_q == LO) | (state_q == HI);

endmodule

// File: tb/tb_add_share_sched.sv
// Bench for add_share_sched: directed requests, a per-cycle reference model
// of result/latency/busy/handshake rules, and literal expectations per test.
module tb_add_share_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 0, req0_wide = 0, req0_sub = 0, req0_cin = 0;
  logic        req1_valid = 0, req1_wide = 0, req1_sub = 0, req1_cin = 0;
  logic [63:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_cout, busy;
  logic [63:0] rsp_sum;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  add_share_sched dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_wide(req0_wide),
    .req0_sub(req0_sub), .req0_cin(req0_cin), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_wide(req1_wide),
    .req1_sub(req1_sub), .req1_cin(req1_cin), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Result of a op b at the requested width: {carry, 64-bit sum}.
  function automatic logic [64:0] model(input bit w, input bit s, input bit c,
                                        input logic [63:0] a, input logic [63:0] b);
    logic [63:0] bb;
    logic [32:0] n;
    logic [64:0] r;
    bb = s ? ~b : b;
    if (w) begin
      r = {1'b0, a} + {1'b0, bb} + {64'h0, c};
    end else begin
      n = {1'b0, a[31:0]} + {1'b0, bb[31:0]} + {32'h0, c};
      r = {n[32], 32'h0, n[31:0]};
    end
    return r;
  endfunction

  // Model state: the single in-flight op and the held response.
  bit          pend = 0;
  int          pend_due = 0, pend_id = 0;
  logic [64:0] pend_res = 0;
  logic [63:0] last_sum = 0;
  logic        last_cout = 0;
  int          bfrom = 1, bto = 0;

  always @(negedge clk) begin : compare
    bit due0, due1, inflight;
    logic [64:0] r;
    if (!rst_n) begin
      chk("rst_rsp0_valid", rsp0_valid, 0);
      chk("rst_rsp1_valid", rsp1_valid, 0);
      chk("rst_rsp_sum", rsp_sum, 0);
      chk("rst_rsp_cout", rsp_cout, 0);
      chk("rst_busy", busy, 0);
      pend = 0; last_sum = 0; last_cout = 0; bfrom = 1; bto = 0;
    end else begin
      due0 = pend && pend_due == cyc && pend_id == 0;
      due1 = pend && pend_due == cyc && pend_id == 1;
      chk("rsp0_valid", rsp0_valid, due0);
      chk("rsp1_valid", rsp1_valid, due1);
      if (due0 || due1) begin
        chk("rsp_sum", rsp_sum, pend_res[63:0]);
        chk("rsp_cout", rsp_cout, pend_res[64]);
        last_sum = pend_res[63:0];
        last_cout = pend_res[64];
        pend = 0;
      end else begin
        chk("rsp_sum_hold", rsp_sum, last_sum);
        chk("rsp_cout_hold", rsp_cout, last_cout);
      end
      inflight = (cyc >= bfrom) && (cyc <= bto);
      chk("busy", busy, inflight);
      chk("ready_count", 64'(req0_ready) + 64'(req1_ready),
          (!inflight && (req0_valid || req1_valid)) ? 1 : 0);
      chk("ready_without_valid", (req0_ready & ~req0_valid) | (req1_ready & ~req1_valid), 0);
      if (req0_valid && req0_ready) begin
        r = model(req0_wide, req0_sub, req0_cin, req0_a, req0_b);
        pend = 1; pend_id = 0; pend_res = r;
        pend_due = cyc + (req0_wide ? 3 : 2);
        bfrom = cyc + 1; bto = cyc + (req0_wide ? 2 : 1);
      end else if (req1_valid && req1_ready) begin
        r = model(req1_wide, req1_sub, req1_cin, req1_a, req1_b);
        pend = 1; pend_id = 1; pend_res = r;
        pend_due = cyc + (req1_wide ? 3 : 2);
        bfrom = cyc + 1; bto = cyc + (req1_wide ? 2 : 1);
      end
    end
  end

  task automatic drive(input int id, input bit w, input bit s, input bit c,
                       input logic [63:0] a, input logic [63:0] b);
    if (id == 0) begin
      req0_wide = w; req0_sub = s; req0_cin = c; req0_a = a; req0_b = b; req0_valid = 1;
    end else begin
      req1_wide = w; req1_sub = s; req1_cin = c; req1_a = a; req1_b = b; req1_valid = 1;
    end
  endtask

  task automatic wait_accept(input int id, output int hcyc);
    bit got;
    got = 0;
    hcyc = -1;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if ((id == 0) ? (req0_valid && req0_ready) : (req1_valid && req1_ready)) begin
        got = 1;
        hcyc = cyc;
      end
    end
    if (!got) chk("accept_timeout", 1, 0);
  endtask

  task automatic drop(input int id);
    @(posedge clk);
    #1;
    if (id == 0) req0_valid = 0; else req1_valid = 0;
  endtask

  task automatic wait_rsp(input int id, output int rcyc);
    bit got;
    got = 0;
    rcyc = -1;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if ((id == 0) ? rsp0_valid : rsp1_valid) begin
        got = 1;
        rcyc = cyc;
      end
    end
    if (!got) chk("rsp_timeout", 1, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #2; rst_n = 0;
    repeat (2) @(posedge clk);
    #2; rst_n = 1;
    @(posedge clk); #1;
  endtask

  int h, h2, rc, cnt, bcnt, n;
  int gid[4], gcyc[4];
  logic [63:0] s;
  logic        c;

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #2; rst_n = 1;
    @(posedge clk); #1;

    // Narrow carry out of bit 31.
    drive(0, 0, 0, 0, 64'h0000_0000_FFFF_FFFF, 64'h1);
    wait_accept(0, h); drop(0); wait_rsp(0, rc);
    chk("narrow_latency", rc - h, 2);
    chk("narrow_sum", rsp_sum, 64'h0);
    chk("narrow_cout", rsp_cout, 1);
    chk("narrow_rsp1_quiet", rsp1_valid, 0);

    // Wide: low carry ripples into the high word.
    drive(1, 1, 0, 0, 64'h0000_0000_FFFF_FFFF, 64'h1);
    wait_accept(1, h); drop(1); wait_rsp(1, rc);
    chk("wide_latency", rc - h, 3);
    chk("wide_sum", rsp_sum, 64'h0000_0001_0000_0000);
    chk("wide_cout", rsp_cout, 0);
    chk("wide_rsp0_quiet", rsp0_valid, 0);

    // Subtract 5 - 7, narrow then wide.
    drive(0, 0, 1, 1, 64'd5, 64'd7);
    wait_accept(0, h); drop(0); wait_rsp(0, rc);
    chk("sub_narrow_sum", rsp_sum, 64'h0000_0000_FFFF_FFFE);
    chk("sub_narrow_cout", rsp_cout, 0);
    drive(0, 1, 1, 1, 64'd5, 64'd7);
    wait_accept(0, h); drop(0); wait_rsp(0, rc);
    chk("sub_wide_sum", rsp_sum, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("sub_wide_cout", rsp_cout, 0);

    // Wide overflow wraps; busy covers exactly the LO and HI cycles.
    drive(0, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
    wait_accept(0, h); drop(0);
    bcnt = 0; cnt = 0; s = '1; c = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (rsp0_valid) begin cnt++; s = rsp_sum; c = rsp_cout; end
    end
    chk("ovf_busy_cycles", bcnt, 2);
    chk("ovf_rsp_count", cnt, 1);
    chk("ovf_sum", s, 64'h0);
    chk("ovf_cout", c, 1);

    // Contention right after reset: strict alternation starting with req0.
    do_reset();
    drive(0, 0, 0, 0, 64'd1, 64'd2);
    drive(1, 0, 0, 0, 64'd10, 64'd20);
    n = 0;
    for (int k = 0; k < 30 && n < 4; k++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        gid[n] = req1_ready ? 1 : 0;
        gcyc[n] = cyc;
        if (n > 0)
          chk("overlap_rsp", gid[n-1] == 1 ? rsp1_valid : rsp0_valid, 1);
        n++;
      end
    end
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    chk("contend_accepts", n, 4);
    for (int k = 0; k < 4; k++) begin
      if (k < n) chk("contend_grant", gid[k], k % 2);
      if (k > 0 && k < n) chk("contend_spacing", gcyc[k] - gcyc[k-1], 2);
    end
    repeat (4) @(negedge clk);
    chk("contend_last_sum", rsp_sum, 64'd30);

    // Reset during HI: response dropped, still-valid requester re-served once.
    drive(0, 1, 0, 0, 64'h1234, 64'h1);
    wait_accept(0, h);
    @(posedge clk);
    @(posedge clk); #2; rst_n = 0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_sum", rsp_sum, 64'h0);
    chk("midrst_rsp0", rsp0_valid, 0);
    @(posedge clk); #2; rst_n = 1;
    wait_accept(0, h2); drop(0);
    cnt = 0; s = '1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rsp0_valid) begin cnt++; s = rsp_sum; end
    end
    chk("midrst_rsp_count", cnt, 1);
    chk("midrst_sum_after", s, 64'h1235);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/add_share_sched.md
Name: add_share_sched

Overview:
- Time-shares one 32-bit adder (add32 with carry in/out) between two requesters, e.g. branch-target and CSR/counter-update logic in the pipeline.
- Round-robin arbitrates the requests and configures the adder for add or subtract.
- Sequences a 64-bit op as two chained 32-bit beats, carrying the low-word carry into the high word.
- Returns a registered result pulse to the granted requester.

Parameters:
- DW, 32: adder word width; fixed at 32, no other value is supported.
- RR_FIRST, 0: requester that wins the first tie after reset.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- reqN_valid  in  1  (N=0,1) request present; must stay high with stable payload until reqN_ready.
- reqN_ready  out  1  (N=0,1) handshake accept.
- reqN_wide  in  1  1 = 64-bit op, 0 = 32-bit op on [31:0].
- reqN_sub  in  1  1 = invert b before adding.
- reqN_cin  in  1  carry-in to the low beat.
- reqN_a  in  64  operand a.
- reqN_b  in  64  operand b.
- rspN_valid  out  1  one-cycle result pulse.
- rsp_sum  out  64  result, shared by both requesters; qualified by rspN_valid.
- rsp_cout  out  1  final carry-out.
- busy  out  1  high in LO and HI.

Behaviour:
- Function: result = a + (sub ? ~b : b) + cin, at 32 or 64 bits. Subtract a-b requires sub=1, cin=1.
- Reset values: state=IDLE, rr_last=~RR_FIRST, rsp0_valid=rsp1_valid=0, rsp_sum=0, rsp_cout=0, busy=0, operand/carry registers=0.
- States: IDLE, LO, HI.
- IDLE:
  - Grant is combinational from valids.
  - If only one requester is valid, it is granted.
  - If both are valid, grant goes to the requester != rr_last.
  - reqN_ready = (state==IDLE) & grant==N. ready may depend on valid; valid must never depend on ready.
  - On handshake: latch a, b (inverted if sub), cin, wide and the grant id; rr_last <= grant; go to LO.
- LO:
  - Adder computes a[31:0] + b'[31:0] + cin; latch sum_lo and c_lo.
  - If wide=0: rsp_sum <= {32'h0, sum_lo}, rsp_cout <= carry, rspG_valid <= 1, go to IDLE.
  - If wide=1: go to HI.
- HI:
  - Adder computes a[63:32] + b'[63:32] + c_lo.
  - rsp_sum <= {sum_hi, sum_lo}, rsp_cout <= carry, rspG_valid <= 1, go to IDLE.
- Latency from the handshake edge to rsp_valid high: narrow 2 cycles, wide 3 cycles.
- rspN_valid is high for exactly one cycle. There is no response backpressure; requesters must sample it.
- Overlap: the IDLE cycle in which rsp_valid is high may accept the next request. Throughput is one narrow op per 2 cycles, one wide op per 3 cycles.
- rsp_sum and rsp_cout hold their last value until the next response.
- Mux: adder inputs are driven from the latched registers only, never directly from request ports. add32 is purely combinational.
- Wrap-around: 64-bit overflow wraps silently. Carry-out is reported via rsp_cout; no other flag.
- Fairness: back-to-back continuous requests from both sides strictly alternate. A single requester may be granted repeatedly.
- Reset mid-operation (LO or HI): the in-flight op is dropped with no response. After rst_n deasserts, state is IDLE, and a still-valid requester is re-granted and gets exactly one response.
- Illegal state encoding recovers to IDLE.

Decomposition:
- Shared header (`include): DW, state encodings IDLE=2'd0, LO=2'd1, HI=2'd2, and the default value of RR_FIRST.
- One sub-module: a single instance of the existing add32 adder. The FSM, arbiter, operand registers and result registers live in add_share_sched.
- A separate arbiter module is not warranted for 2 requesters.

Test Plan:
- Narrow carry: req0 a=0x0000_0000_FFFF_FFFF, b=1, cin=0, wide=0 -> rsp0_valid 2 cycles after handshake, rsp_sum=0x0, rsp_cout=1.
- Wide carry chain: req1 same operands, wide=1 -> rsp1_valid after 3 cycles, rsp_sum=0x0000_0001_0000_0000, rsp_cout=0. rsp0_valid stays 0.
- Subtract: req0 a=5, b=7, sub=1, cin=1, narrow -> rsp_sum=0x0000_0000_FFFF_FFFE, rsp_cout=0. Repeat wide -> rsp_sum=0xFFFF_FFFF_FFFF_FFFE, rsp_cout=0.
- Contention after reset: both valid continuously, narrow -> grants req0, req1, req0, req1. ready pulses one cycle each, 2 cycles apart. The next accept coincides with the previous rsp_valid.
- Reset mid-HI: req0 wide, rst_n low during HI -> no rsp0_valid; busy=0 and rsp_sum=0 at once. After release, req0 (still valid) is re-accepted and answered exactly once.
- Wide overflow: a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0 -> rsp_sum=0, rsp_cout=1. busy high for exactly 2 cycles.
